// File: rtl/cache_port_arbiter.sv
// Round-robin two-requester sequencer for the single-line byte cache: one registered
// command per cycle, per-byte valid mask for hit reporting, and a one-cycle line flush.
module cache_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int OFF_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [OFF_W-1:0]  a_off,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_hit,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [OFF_W-1:0]  b_off,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_hit,
  input  logic              flush,
  output logic              flush_busy,
  output logic              cache_wren,
  output logic [DATA_W-1:0] cache_data,
  output logic [OFF_W-1:0]  cache_wroffset,
  output logic [OFF_W-1:0]  cache_rdoffset,
  input  logic [DATA_W-1:0] cache_q
);

  localparam int LINE = 1 << OFF_W;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  state_t              state, state_nxt;
  logic                last_b;
  logic                pick_a, pick_b, issue;
  logic                sel_we;
  logic [OFF_W-1:0]    sel_off;
  logic [DATA_W-1:0]   sel_wdata;
  logic                cmd_rd_p0;
  logic [LINE-1:0]     valid_mask;

  // Decide, from the requests present at this edge, what the next cycle issues.
  always_comb begin
    state_nxt = IDLE;
    pick_a    = a_req & (~b_req | last_b);
    pick_b    = b_req & ~pick_a;
    sel_we    = pick_a ? a_we    : b_we;
    sel_off   = pick_a ? a_off   : b_off;
    sel_wdata = pick_a ? a_wdata : b_wdata;
    case (state)
      FLUSH:   state_nxt = IDLE;
      default: begin
        if (flush)               state_nxt = FLUSH;
        else if (a_req || b_req) state_nxt = ISSUE;
        else                     state_nxt = IDLE;
      end
    endcase
    issue = (state_nxt == ISSUE);
  end

  assign flush_busy = (state == FLUSH);

  // p0: command cycle registers; p1: read return captured at the end of the command cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_b         <= 1'b1;
      a_gnt          <= 1'b0;
      b_gnt          <= 1'b0;
      cache_wren     <= 1'b0;
      cmd_rd_p0      <= 1'b0;
      cache_data     <= '0;
      cache_wroffset <= '0;
      cache_rdoffset <= '0;
      valid_mask     <= '0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
      a_rdata        <= '0;
      b_rdata        <= '0;
      a_hit          <= 1'b0;
      b_hit          <= 1'b0;
    end else begin
      state      <= state_nxt;
      a_gnt      <= issue & pick_a;
      b_gnt      <= issue & pick_b;
      cache_wren <= issue & sel_we;
      cmd_rd_p0  <= issue & ~sel_we;
      if (issue) begin
        last_b <= pick_b;
        if (sel_we) begin
          cache_data     <= sel_wdata;
          cache_wroffset <= sel_off;
        end else begin
          cache_rdoffset <= sel_off;
        end
      end

      if (state == FLUSH)  valid_mask <= '0;
      else if (cache_wren) valid_mask[cache_wroffset] <= 1'b1;

      a_rvalid <= a_gnt & cmd_rd_p0;
      b_rvalid <= b_gnt & cmd_rd_p0;
      if (a_gnt && cmd_rd_p0) begin
        a_rdata <= cache_q;
        a_hit   <= valid_mask[cache_rdoffset];
      end
      if (b_gnt && cmd_rd_p0) begin
        b_rdata <= cache_q;
        b_hit   <= valid_mask[cache_rdoffset];
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: a byte-cache model plus a queue-based scoreboard whose
// monitor checks every grant's cache command and every read return.
module tb_cache_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, flush = 1'b0;
  logic [4:0] a_off = '0, b_off = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_gnt, a_rvalid, a_hit, b_gnt, b_rvalid, b_hit, flush_busy, cache_wren;
  logic [7:0] a_rdata, b_rdata, cache_data, cache_q;
  logic [4:0] cache_wroffset, cache_rdoffset;

  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;

  typedef struct {bit port; bit we; logic [4:0] off; logic [7:0] data;} gnt_t;
  typedef struct {bit port; logic [7:0] data; bit hit;} rd_t;
  gnt_t exp_gnt[$];
  rd_t  exp_rd[$];

  cache_port_arbiter #(.DATA_W(8), .OFF_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_off(a_off), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_hit(a_hit),
    .b_req(b_req), .b_we(b_we), .b_off(b_off), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_hit(b_hit),
    .flush(flush), .flush_busy(flush_busy),
    .cache_wren(cache_wren), .cache_data(cache_data),
    .cache_wroffset(cache_wroffset), .cache_rdoffset(cache_rdoffset),
    .cache_q(cache_q)
  );

  always #5 clk = ~clk;

  // Single-line cache: synchronous write, asynchronous read.
  initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  always @(posedge clk) if (cache_wren) mem[cache_wroffset] <= cache_data;
  assign cache_q = mem[cache_rdoffset];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: pops expectations whenever the DUT grants or returns read data.
  always @(negedge clk) begin
    if (a_gnt || b_gnt) begin
      checks++;
      if (a_gnt && b_gnt) begin
        errors++;
        $display("FAIL both_gnt a_gnt=%0b b_gnt=%0b required one-hot", a_gnt, b_gnt);
      end else if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gnt a_gnt=%0b b_gnt=%0b required none", a_gnt, b_gnt);
      end else begin
        gnt_t g;
        bit ok;
        g = exp_gnt.pop_front();
        ok = (b_gnt == g.port) && (cache_wren == g.we);
        if (g.we) ok = ok && (cache_wroffset == g.off) && (cache_data == g.data);
        else      ok = ok && (cache_rdoffset == g.off);
        if (!ok) begin
          errors++;
          $display("FAIL gnt_cmd got port=%0d wren=%0b wroff=%0d data=%h rdoff=%0d required port=%0d we=%0b off=%0d data=%h",
                   b_gnt, cache_wren, cache_wroffset, cache_data, cache_rdoffset, g.port, g.we, g.off, g.data);
        end
      end
    end
    if (a_rvalid || b_rvalid) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid a_rvalid=%0b b_rvalid=%0b required none", a_rvalid, b_rvalid);
      end else begin
        rd_t r;
        logic [7:0] d;
        logic h;
        r = exp_rd.pop_front();
        d = a_rvalid ? a_rdata : b_rdata;
        h = a_rvalid ? a_hit : b_hit;
        if ((a_rvalid && b_rvalid) || (b_rvalid != r.port) || d != r.data || h != r.hit) begin
          errors++;
          $display("FAIL read_return got port=%0d data=%h hit=%0b required port=%0d data=%h hit=%0b",
                   b_rvalid, d, h, r.port, r.data, r.hit);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic push_exp(input bit port, input bit we, input logic [4:0] off, input logic [7:0] data,
                          input logic [7:0] ed, input bit eh, input bit want_rd);
    gnt_t g;
    rd_t  r;
    g = '{port, we, off, data};
    exp_gnt.push_back(g);
    if (!we && want_rd) begin
      r = '{port, ed, eh};
      exp_rd.push_back(r);
    end
  endtask

  task automatic drive(input bit port, input bit we, input logic [4:0] off, input logic [7:0] data);
    if (port == 1'b0) begin
      a_req = 1'b1; a_we = we; a_off = off; a_wdata = data;
    end else begin
      b_req = 1'b1; b_we = we; b_off = off; b_wdata = data;
    end
  endtask

  task automatic wait_gnts(input bit wa, input bit wb);
    int n = 0;
    bit pa = wa;
    bit pb = wb;
    while ((pa || pb) && n < 20) begin
      @(negedge clk);
      n++;
      if (pa && a_gnt) begin a_req = 1'b0; pa = 1'b0; end
      if (pb && b_gnt) begin b_req = 1'b0; pb = 1'b0; end
    end
    checks++;
    if (pa || pb) begin
      errors++;
      $display("FAIL gnt_timeout pending_a=%0b pending_b=%0b required none pending", pa, pb);
      a_req = 1'b0;
      b_req = 1'b0;
    end
  endtask

  task automatic do_op(input bit port, input bit we, input logic [4:0] off, input logic [7:0] data,
                       input logic [7:0] ed, input bit eh);
    push_exp(port, we, off, data, ed, eh, 1'b1);
    drive(port, we, off, data);
    wait_gnts(port == 1'b0, port == 1'b1);
  endtask

  initial begin
    int ng;
    int n;

    // Test 1: reset state, then a read of an unwritten byte misses.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_gnt", a_gnt, 0);       check("rst_b_gnt", b_gnt, 0);
    check("rst_a_rvalid", a_rvalid, 0); check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);   check("rst_b_rdata", b_rdata, 0);
    check("rst_a_hit", a_hit, 0);       check("rst_b_hit", b_hit, 0);
    check("rst_flush_busy", flush_busy, 0);
    check("rst_cache_wren", cache_wren, 0);
    check("rst_cache_data", cache_data, 0);
    check("rst_cache_wroffset", cache_wroffset, 0);
    check("rst_cache_rdoffset", cache_rdoffset, 0);
    rst = 1'b0;
    do_op(1'b1, 1'b0, 5'd7, 8'h00, 8'h00, 1'b0);

    // Test 3: both requesters reading continuously alternate, A first.
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 1'b0, 5'd1, 8'h00, 8'h00, 1'b0, 1'b1);
      push_exp(1'b1, 1'b0, 5'd2, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 5'd1, 8'h00);
    drive(1'b1, 1'b0, 5'd2, 8'h00);
    ng = 0;
    n  = 0;
    while (ng < 6 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check("t3_first_gnt_a", a_gnt, 1);
      if (a_gnt || b_gnt) ng++;
      if (ng == 6) begin a_req = 1'b0; b_req = 1'b0; end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("t3_grant_count", ng, 6);

    // Test 2: write then read the same byte from A.
    do_op(1'b0, 1'b1, 5'd3, 8'h5A, 8'h00, 1'b0);
    do_op(1'b0, 1'b0, 5'd3, 8'h00, 8'h5A, 1'b1);

    // Test 4: B writes the last byte, A reads it on the very next cycle.
    push_exp(1'b1, 1'b1, 5'd31, 8'hC3, 8'h00, 1'b0, 1'b1);
    push_exp(1'b0, 1'b0, 5'd31, 8'h00, 8'hC3, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 5'd31, 8'hC3);
    drive(1'b0, 1'b0, 5'd31, 8'h00);
    wait_gnts(1'b1, 1'b1);

    // Test 5: fill the line, flush with both requesters pending, then reads miss.
    for (int i = 0; i < 32; i++) begin
      logic [7:0] d;
      d = 8'(i) ^ 8'hA5;
      do_op(1'b0, 1'b1, 5'(i), d, 8'h00, 1'b0);
    end
    push_exp(1'b1, 1'b0, 5'd6, 8'h00, 8'hA3, 1'b0, 1'b1);
    push_exp(1'b0, 1'b0, 5'd5, 8'h00, 8'hA0, 1'b0, 1'b1);
    flush = 1'b1;
    drive(1'b0, 1'b0, 5'd5, 8'h00);
    drive(1'b1, 1'b0, 5'd6, 8'h00);
    @(negedge clk);
    flush = 1'b0;
    check("t5_flush_busy", flush_busy, 1);
    check("t5_no_gnt_in_flush", a_gnt | b_gnt, 0);
    @(negedge clk);
    check("t5_flush_one_cycle", flush_busy, 0);
    wait_gnts(1'b1, 1'b1);

    // Test 6: reset during a read issue cycle cancels the return and clears the mask.
    do_op(1'b0, 1'b1, 5'd3, 8'h77, 8'h00, 1'b0);
    push_exp(1'b0, 1'b0, 5'd3, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd3, 8'h00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_gnt && n < 20);
    check("t6_read_granted", a_gnt, 1);
    rst   = 1'b1;
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_no_rvalid", a_rvalid, 0);
    check("t6_no_gnt", a_gnt | b_gnt, 0);
    push_exp(1'b0, 1'b0, 5'd3, 8'h00, 8'h77, 1'b0, 1'b1);
    push_exp(1'b1, 1'b0, 5'd3, 8'h00, 8'h77, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 5'd3, 8'h00);
    drive(1'b1, 1'b0, 5'd3, 8'h00);
    wait_gnts(1'b1, 1'b1);

    repeat (4) @(negedge clk);
    check("exp_gnt_drained", exp_gnt.size(), 0);
    check("exp_rd_drained", exp_rd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
